// File: rtl/mem_bus_arbiter.sv
// Two-port external bus arbiter with programmable wait states and one-cycle ack.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module mem_bus_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int CW          = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          wr0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          wr1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          cpu_stall,
  output logic          bus_cs,
  output logic          bus_wr_rd,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          bus_cs_q, bus_cs_d;
  logic          bus_wr_rd_q, bus_wr_rd_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;

  logic tie_pick1;
  logic grant1;

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_pick1 = ~last_grant_q;
`else
  assign tie_pick1 = 1'b0;
`endif

  // Port 1 wins when it is alone, or when it wins a tie.
  assign grant1 = req1 & (~req0 | tie_pick1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    ack0_d       = ack0_q;
    ack1_d       = ack1_q;
    rdata_d      = rdata_q;
    bus_cs_d     = bus_cs_q;
    bus_wr_rd_d  = bus_wr_rd_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          owner_d     = grant1;
          bus_cs_d    = 1'b1;
          bus_wr_rd_d = grant1 ? wr1 : wr0;
          bus_addr_d  = grant1 ? addr1 : addr0;
          bus_wdata_d = grant1 ? wdata1 : wdata0;
          cnt_d       = CW'(WAIT_CYCLES);
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          rdata_d     = bus_rdata;
          bus_cs_d    = 1'b0;
          bus_wr_rd_d = 1'b0;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
          ack0_d      = ~owner_q;
          ack1_d      = owner_q;
          state_d     = DONE;
        end
      end
      DONE: begin
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        last_grant_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata_q      <= '0;
      bus_cs_q     <= 1'b0;
      bus_wr_rd_q  <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata_q      <= rdata_d;
      bus_cs_q     <= bus_cs_d;
      bus_wr_rd_q  <= bus_wr_rd_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign bus_cs    = bus_cs_q;
  assign bus_wr_rd = bus_wr_rd_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  // CPU is released in its ack cycle.
  assign cpu_stall = req0 & ~ack0_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: WAIT_CYCLES=1 main instance plus a WAIT_CYCLES=0 instance.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0, bus_rdata = '0;
  logic          ack0, ack1, cpu_stall, bus_cs, bus_wr_rd;
  logic [DW-1:0] rdata, bus_wdata;
  logic [AW-1:0] bus_addr;

  logic          z_req0 = 1'b0, z_zero = 1'b0;
  logic          z_ack0, z_ack1, z_stall, z_cs, z_wr_rd;
  logic [DW-1:0] z_rdata, z_wdata;
  logic [AW-1:0] z_addr;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_order;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(1), .CW(4)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .wr0(wr0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .wr1(wr1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .cpu_stall(cpu_stall),
    .bus_cs(bus_cs), .bus_wr_rd(bus_wr_rd), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  mem_bus_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(0), .CW(4)) u_dut_w0 (
    .clk(clk), .rst(rst),
    .req0(z_req0), .addr0(addr0), .wdata0(wdata0), .wr0(wr0),
    .req1(z_zero), .addr1(addr1), .wdata1(wdata1), .wr1(wr1),
    .ack0(z_ack0), .ack1(z_ack1), .rdata(z_rdata), .cpu_stall(z_stall),
    .bus_cs(z_cs), .bus_wr_rd(z_wr_rd), .bus_addr(z_addr),
    .bus_wdata(z_wdata), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b0000;
`endif
    #1 rst = 1'b1;
    repeat (2) tick();
    chk("rst_cs", 64'(bus_cs), 64'd0);
    chk("rst_ack", 64'({ack1, ack0}), 64'd0);
    chk("rst_addr", 64'(bus_addr), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    rst = 1'b0;
    tick();

    // Port 0 read, WAIT_CYCLES=1: bus_cs cycles 1-2, ack cycle 3.
    req0 = 1'b1; addr0 = 32'h10; wr0 = 1'b0; bus_rdata = 32'hDEADBEEF;
    #1;
    chk("rd_c0_stall", 64'(cpu_stall), 64'd1);
    chk("rd_c0_cs", 64'(bus_cs), 64'd0);
    for (int c = 1; c <= 2; c++) begin
      tick();
      chk("rd_cs", 64'(bus_cs), 64'd1);
      chk("rd_addr", 64'(bus_addr), 64'h10);
      chk("rd_wr", 64'(bus_wr_rd), 64'd0);
      chk("rd_noack", 64'({ack1, ack0}), 64'd0);
      chk("rd_stall", 64'(cpu_stall), 64'd1);
    end
    tick();
    chk("rd_ack0", 64'({ack1, ack0}), 64'b01);
    chk("rd_rdata", 64'(rdata), 64'hDEADBEEF);
    chk("rd_stall_rel", 64'(cpu_stall), 64'd0);
    chk("rd_cs_off", 64'(bus_cs), 64'd0);
    req0 = 1'b0;
    bus_rdata = 32'h55AA55AA;
    tick();
    chk("rd_ack_end", 64'({ack1, ack0}), 64'd0);
    chk("rd_rdata_hold", 64'(rdata), 64'hDEADBEEF);

    // Port 1 write.
    req1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h1234; wr1 = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      tick();
      chk("wr_cs", 64'(bus_cs), 64'd1);
      chk("wr_dir", 64'(bus_wr_rd), 64'd1);
      chk("wr_wdata", 64'(bus_wdata), 64'h1234);
      chk("wr_addr", 64'(bus_addr), 64'h20);
    end
    tick();
    chk("wr_ack", 64'({ack1, ack0}), 64'b10);
    chk("wr_cs_off", 64'(bus_cs), 64'd0);
    req1 = 1'b0; wr1 = 1'b0;
    tick();
    chk("wr_idle", 64'({ack1, ack0, bus_cs}), 64'd0);

    // Continuous contention: one access every 4 cycles.
    req0 = 1'b1; addr0 = 32'h100; req1 = 1'b1; addr1 = 32'h200;
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      chk("arb_addr", 64'(bus_addr), exp_order[k] ? 64'h200 : 64'h100);
      tick();
      chk("arb_ack", 64'({ack1, ack0}), exp_order[k] ? 64'b10 : 64'b01);
      if (k == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      tick();
      chk("arb_gap", 64'({ack1, ack0, bus_cs}), 64'd0);
    end

    // Port 1 arrives during port 0's access and waits its turn.
    req0 = 1'b1; addr0 = 32'h30;
    tick();
    req1 = 1'b1; addr1 = 32'h40;
    tick();
    chk("late_addr0", 64'(bus_addr), 64'h30);
    tick();
    chk("late_ack0", 64'({ack1, ack0}), 64'b01);
    req0 = 1'b0;
    tick();
    chk("late_idle", 64'({ack1, ack0, bus_cs}), 64'd0);
    tick();
    chk("late_cs1", 64'(bus_cs), 64'd1);
    chk("late_addr1", 64'(bus_addr), 64'h40);
    tick();
    chk("late_cs1b", 64'(bus_cs), 64'd1);
    tick();
    chk("late_ack1", 64'({ack1, ack0}), 64'b10);
    req1 = 1'b0;
    tick();

    // Reset in the middle of an access.
    req0 = 1'b1; addr0 = 32'h50;
    tick();
    chk("mid_cs", 64'(bus_cs), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cs", 64'(bus_cs), 64'd0);
    chk("mid_rst_ack", 64'({ack1, ack0}), 64'd0);
    chk("mid_rst_addr", 64'(bus_addr), 64'd0);
    chk("mid_rst_stall", 64'(cpu_stall), 64'd1);
    req0 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("post_rst_quiet", 64'({ack1, ack0, bus_cs}), 64'd0);
    end

    // Zero wait states: bus_cs for one cycle, ack two cycles after request.
    z_req0 = 1'b1; addr0 = 32'h60; wr0 = 1'b0; bus_rdata = 32'hCAFE0001;
    tick();
    chk("w0_cs", 64'(z_cs), 64'd1);
    chk("w0_addr", 64'(z_addr), 64'h60);
    chk("w0_noack", 64'(z_ack0), 64'd0);
    tick();
    chk("w0_ack", 64'({z_ack1, z_ack0}), 64'b01);
    chk("w0_cs_off", 64'(z_cs), 64'd0);
    chk("w0_rdata", 64'(z_rdata), 64'hCAFE0001);
    chk("w0_stall", 64'(z_stall), 64'd0);
    z_req0 = 1'b0;
    tick();
    chk("w0_end", 64'({z_ack0, z_cs}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
